// File: rtl/dmem_pkg.sv
// Shared encodings and types for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Reserved size or a half/word access that crosses its natural alignment.
  function automatic logic bad_size_align(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte-enables and data replication, load align and extend.
// Purely combinational, zero latency, no flow control.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        sgn_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] rdata_o
);

  logic [4:0]  shamt;
  logic [31:0] shifted;

  always_comb begin
    be_o        = 4'b0000;
    wdata_rep_o = wdata_i;
    shamt       = 5'd0;
    case (size_i)
      SZ_BYTE: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_rep_o = {4{wdata_i[7:0]}};
        shamt       = {addr_lo_i, 3'b000};
      end
      SZ_HALF: begin
        be_o        = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_rep_o = {2{wdata_i[15:0]}};
        shamt       = {addr_lo_i[1], 4'b0000};
      end
      SZ_WORD: begin
        be_o        = 4'b1111;
        wdata_rep_o = wdata_i;
        shamt       = 5'd0;
      end
      default: begin
        be_o        = 4'b0000;
        wdata_rep_o = wdata_i;
        shamt       = 5'd0;
      end
    endcase
  end

  assign shifted = rword_i >> shamt;

  always_comb begin
    rdata_o = shifted;
    case (size_i)
      SZ_BYTE: rdata_o = {{24{sgn_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata_o = {{16{sgn_i & shifted[15]}}, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-port data memory answering one load/store at a time over valid/ready.
// Response strobe two cycles after acceptance; req_ready low while a request is in flight.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = 2048
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS) << 2;

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]      offset;
  logic [IDX_W-1:0] widx;
  logic             err;
  logic             accept;
  logic             wr_en;
  logic [3:0]       be;
  logic [31:0]      wdata_rep;
  logic [31:0]      rdata_ext;

  assign accept = (state_q == IDLE) && req_valid;
  assign offset = req_q.addr - BASE_ADDR;
  assign widx   = offset[IDX_W+1:2];
  // Full 32-bit compare also rejects addresses below BASE_ADDR via wraparound.
  assign err    = (offset >= SPAN) || bad_size_align(req_q.size, req_q.addr[1:0]);
  assign wr_en  = (state_q == ACCESS) && req_q.we && !err;

  dmem_lane_align u_lane_align (
    .size_i      (req_q.size),
    .addr_lo_i   (req_q.addr[1:0]),
    .sgn_i       (req_q.sgn),
    .wdata_i     (req_q.wdata),
    .rword_i     (mem_q[widx]),
    .be_o        (be),
    .wdata_rep_o (wdata_rep),
    .rdata_o     (rdata_ext)
  );

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      req_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
  end

  always_comb begin
    req_d = req_q;
    if (accept) begin
      req_d.we    = req_we;
      req_d.size  = req_size;
      req_d.sgn   = req_signed;
      req_d.addr  = req_addr;
      req_d.wdata = req_wdata;
    end
  end

  always_comb begin
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (state_q == ACCESS) begin
      rsp_err_d   = err;
      rsp_rdata_d = (err || req_q.we) ? 32'h0 : rdata_ext;
    end
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Contents survive reset; an async reset forces IDLE so an aborted store never commits.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[widx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expected responses, a monitor checks them.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  time  last_acc_t;

  always #5 clk_in = ~clk_in;

  dmem_responder dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every response strobe must match the oldest outstanding expectation.
  always @(negedge clk_in) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp got rdata %h err %0b want no response", rsp_rdata, rsp_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
        chk({e.name, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input string nm, input bit keep, input bit push);
    int guard;
    exp_t e;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk_in);
      guard++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout got req_ready %b want 1", nm, req_ready);
    end
    @(posedge clk_in);
    last_acc_t = $time;
    if (push) begin
      e.name  = nm;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      exp_q.push_back(e);
    end
    @(negedge clk_in);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    chk({nm, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({nm, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({nm, "_rsp_err"},   {31'b0, rsp_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    time t0, t1, t2;
    int  guard;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_WORD;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    #1;
    chk_reset_outputs("por");
    repeat (2) @(negedge clk_in);
    reset = 1'b0;

    // Leave a sticky error in the response registers, then reset mid-run.
    issue(1'b1, SZ_WORD, 1'b0, 32'h1001_0004, 32'h1111_1111, 32'h0, 1'b0, "st_w1", 1'b0, 1'b1);
    issue(1'b0, SZ_WORD, 1'b0, 32'h1001_0002, 32'h0, 32'h0, 1'b1, "ld_misal_w", 1'b0, 1'b1);
    @(negedge clk_in);
    @(negedge clk_in);
    chk("err_hold_idle", {31'b0, rsp_err}, 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_outputs("midrun");
    @(negedge clk_in);
    reset = 1'b0;

    issue(1'b1, SZ_WORD, 1'b0, 32'h1001_0000, 32'hDEAD_BEEF, 32'h0, 1'b0, "st_deadbeef", 1'b0, 1'b1);
    chk("busy1_ready", {31'b0, req_ready}, 32'd0);
    chk("busy1_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk_in);
    chk("busy2_ready", {31'b0, req_ready}, 32'd0);
    chk("busy2_valid", {31'b0, rsp_valid}, 32'd1);
    @(negedge clk_in);
    chk("after_ready", {31'b0, req_ready}, 32'd1);
    chk("after_valid", {31'b0, rsp_valid}, 32'd0);

    issue(1'b0, SZ_BYTE, 1'b1, 32'h1001_0003, 32'h0, 32'hFFFF_FFDE, 1'b0, "ld_b_s3", 1'b0, 1'b1);
    issue(1'b0, SZ_HALF, 1'b0, 32'h1001_0000, 32'h0, 32'h0000_BEEF, 1'b0, "ld_h_u0", 1'b0, 1'b1);
    issue(1'b0, SZ_HALF, 1'b1, 32'h1001_0002, 32'h0, 32'hFFFF_DEAD, 1'b0, "ld_h_s2", 1'b0, 1'b1);
    issue(1'b0, SZ_BYTE, 1'b0, 32'h1001_0000, 32'h0, 32'h0000_00EF, 1'b0, "ld_b_u0", 1'b0, 1'b1);
    issue(1'b0, SZ_WORD, 1'b1, 32'h1001_0000, 32'h0, 32'hDEAD_BEEF, 1'b0, "ld_w_sgn", 1'b0, 1'b1);

    issue(1'b1, SZ_BYTE, 1'b0, 32'h1001_0001, 32'hAAAA_AA12, 32'h0, 1'b0, "st_b1", 1'b0, 1'b1);
    issue(1'b0, SZ_WORD, 1'b0, 32'h1001_0000, 32'h0, 32'hDEAD_12EF, 1'b0, "ld_w_merge", 1'b0, 1'b1);

    // Rejected requests: misaligned, below base, one past the end, reserved size.
    issue(1'b0, SZ_WORD, 1'b0, 32'h1001_0002, 32'h0, 32'h0, 1'b1, "e_ld_w2", 1'b0, 1'b1);
    issue(1'b0, SZ_HALF, 1'b0, 32'h1001_0001, 32'h0, 32'h0, 1'b1, "e_ld_h1", 1'b0, 1'b1);
    issue(1'b0, SZ_WORD, 1'b0, 32'h1000_FFFC, 32'h0, 32'h0, 1'b1, "e_ld_below", 1'b0, 1'b1);
    issue(1'b0, SZ_BYTE, 1'b0, 32'h1001_2000, 32'h0, 32'h0, 1'b1, "e_ld_end", 1'b0, 1'b1);
    issue(1'b0, SZ_RSVD, 1'b0, 32'h1001_0000, 32'h0, 32'h0, 1'b1, "e_ld_sz3", 1'b0, 1'b1);
    issue(1'b1, SZ_WORD, 1'b0, 32'h1001_0002, 32'hFFFF_FFFF, 32'h0, 1'b1, "e_st_w2", 1'b0, 1'b1);
    issue(1'b1, SZ_HALF, 1'b0, 32'h1001_0001, 32'hFFFF_FFFF, 32'h0, 1'b1, "e_st_h1", 1'b0, 1'b1);
    issue(1'b1, SZ_WORD, 1'b0, 32'h1001_2000, 32'hFFFF_FFFF, 32'h0, 1'b1, "e_st_end", 1'b0, 1'b1);
    issue(1'b1, SZ_RSVD, 1'b0, 32'h1001_0000, 32'hFFFF_FFFF, 32'h0, 1'b1, "e_st_sz3", 1'b0, 1'b1);
    issue(1'b0, SZ_WORD, 1'b0, 32'h1001_0000, 32'h0, 32'hDEAD_12EF, 1'b0, "ld_unchanged", 1'b0, 1'b1);

    // Word 1 was stored before the mid-run reset, so it must still be there.
    issue(1'b1, SZ_HALF, 1'b0, 32'h1001_0006, 32'h5555_CAFE, 32'h0, 1'b0, "st_h6", 1'b0, 1'b1);
    issue(1'b0, SZ_WORD, 1'b0, 32'h1001_0004, 32'h0, 32'hCAFE_1111, 1'b0, "ld_w4", 1'b0, 1'b1);
    issue(1'b1, SZ_WORD, 1'b0, 32'h1001_1FFC, 32'h0123_4567, 32'h0, 1'b0, "st_last", 1'b0, 1'b1);
    issue(1'b0, SZ_WORD, 1'b0, 32'h1001_1FFC, 32'h0, 32'h0123_4567, 1'b0, "ld_last", 1'b0, 1'b1);

    // req_valid held high across three requests.
    issue(1'b1, SZ_WORD, 1'b0, 32'h1001_0008, 32'h0BAD_F00D, 32'h0, 1'b0, "b2b_st", 1'b1, 1'b1);
    t0 = last_acc_t;
    issue(1'b0, SZ_WORD, 1'b0, 32'h1001_0008, 32'h0, 32'h0BAD_F00D, 1'b0, "b2b_ld_w", 1'b1, 1'b1);
    t1 = last_acc_t;
    issue(1'b0, SZ_BYTE, 1'b0, 32'h1001_000B, 32'h0, 32'h0000_000B, 1'b0, "b2b_ld_b", 1'b0, 1'b1);
    t2 = last_acc_t;
    chk("b2b_gap1", 32'(t1 - t0), 32'd30);
    chk("b2b_gap2", 32'(t2 - t1), 32'd30);

    // Store aborted by reset while in ACCESS must neither respond nor commit.
    issue(1'b1, SZ_WORD, 1'b0, 32'h1001_0010, 32'hA5A5_A5A5, 32'h0, 1'b0, "st_a5", 1'b0, 1'b1);
    issue(1'b1, SZ_BYTE, 1'b0, 32'h1001_0010, 32'h0000_0055, 32'h0, 1'b0, "abort_st", 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk("abort_no_valid", {31'b0, rsp_valid}, 32'd0);
    end
    issue(1'b0, SZ_WORD, 1'b0, 32'h1001_0010, 32'h0, 32'hA5A5_A5A5, 1'b0, "ld_after_abort", 1'b0, 1'b1);
    issue(1'b0, SZ_BYTE, 1'b0, 32'h1001_0010, 32'h0, 32'h0000_00A5, 1'b0, "ld_b_after_abort", 1'b0, 1'b1);

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk_in);
      guard++;
    end
    chk("drain_outstanding", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1001_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 2048, number of 32-bit words stored (power of two).
REQ-003 SHALL have ports: clk_in  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: req_valid  in  1  request present; req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-005 SHALL have ports: req_we  in  1  1=store, 0=load; req_size  in  2  00 byte, 01 half, 10 word, 11 reserved; req_signed  in  1  sign-extend load.
REQ-006 SHALL have ports: req_addr  in  32  byte address; req_wdata  in  32  store data, right-justified.
REQ-007 SHALL have ports: rsp_valid  out  1  one-cycle response strobe; rsp_rdata  out  32  load data; rsp_err  out  1  request rejected.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, RESP; req_ready SHALL be high only in IDLE.
REQ-009 SHALL accept a request on the rising edge with req_valid&&req_ready, capture all req_* fields, and move IDLE->ACCESS.
REQ-010 SHALL move ACCESS->RESP unconditionally and RESP->IDLE unconditionally; rsp_valid high exactly in RESP; acceptance at edge N gives rsp_valid in the cycle after edge N+1.
REQ-011 SHALL compute offset = req_addr - BASE_ADDR (32-bit wrap), word index = offset[31:2].
REQ-012 SHALL flag error when offset >= DEPTH_WORDS*4, when req_size==11, when half with addr[0]=1, or when word with addr[1:0]!=00.
REQ-013 On error: no memory write, rsp_rdata=0, rsp_err=1 during RESP.
REQ-014 Stores SHALL commit on the ACCESS->RESP edge, little-endian lanes: byte writes lane addr[1:0] with wdata[7:0]; half writes lanes {addr[1],0}+1:{addr[1],0} with wdata[15:0]; word writes all lanes; unselected lanes unchanged.
REQ-015 Loads SHALL read the word on the ACCESS->RESP edge, shift the selected lane(s) to bit 0, zero- or sign-extend per captured req_signed (ignored for word).
REQ-016 Store responses SHALL drive rsp_rdata=0, rsp_err=0 (unless error).
REQ-017 rsp_rdata/rsp_err SHALL be registered, hold their value outside RESP, and rsp_valid SHALL be 0 outside RESP.
REQ-018 req_valid asserted outside IDLE SHALL be ignored (not queued); requester holds it until req_ready.
REQ-019 A load immediately following a store to the same address SHALL return the stored data.

Reset
REQ-020 On reset assertion, asynchronously: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-021 Reset during ACCESS SHALL abort the request with no memory write and no response.
REQ-022 Memory contents SHALL NOT be reset.

Structure
REQ-023 Shared package dmem_pkg SHALL hold size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, default BASE_ADDR.
REQ-024 Lane byte-enable generation, store data replication and load align/extend SHALL live in combinational sub-module dmem_lane_align.
REQ-025 Storage SHALL be a DEPTH_WORDS x 32 array with per-byte write enables.

Verification
REQ-026 Reset mid-run then req word store 0xDEADBEEF @0x10010000 -> req_ready=0 two cycles, rsp_valid one cycle, rsp_err=0, rsp_rdata=0.
REQ-027 Then byte load signed @0x10010003 -> rsp_rdata=0xFFFFFFDE; unsigned half @0x10010000 -> 0x0000BEEF.
REQ-028 Byte store 0x12 @0x10010001 then word load @0x10010000 -> 0xDEAD12EF.
REQ-029 Word load @0x10010002, half @0x10010001, any @0x1000FFFC, any @0x10012000, size 11 -> each rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-030 Back-to-back req_valid held high for 3 requests -> one accepted every 3 cycles, responses in order.
REQ-031 Reset asserted during ACCESS of store 0x55 @0x10010010 -> no rsp_valid; later load there returns prior contents.
